// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the data-memory controller state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      RESP      = 2'd2
   } dmem_state_t;

endpackage : cpu_pkg

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 2**ADDR_W x DATA_W, registered read, no reset.
// Latency: read data appears on o_rdata one edge after an enabled read.
// Backpressure: none; o_rdata holds until the next enabled read.
module dmem_ram #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
) (
   input  logic              i_clock,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // One access per enabled edge: write when i_we, otherwise capture read data
   always_ff @(posedge i_clock) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule : dmem_ram

// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the core's memory stage: RAM plus one MMIO debug register.
// Latency: store responds 1 edge after acceptance, load RD_LAT edges after acceptance.
// Backpressure: req_ready only in IDLE; held requests wait, nothing is queued.
module data_mem_ctrl #(
   parameter int DATA_W    = cpu_pkg::DATA_W,
   parameter int ADDR_W    = cpu_pkg::ADDR_W,
   parameter int RD_LAT    = 2,
   parameter int MMIO_ADDR = 63
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [DATA_W-1:0] mmio_out
);

   import cpu_pkg::*;

   localparam int                CNT_W  = 4;
   localparam logic [CNT_W-1:0]  LD_CNT = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
   localparam logic [ADDR_W-1:0] MMIO_A = ADDR_W'(MMIO_ADDR);

   dmem_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_rsp_ld;     // access in flight is a load
   logic              r_rsp_mmio;   // access in flight targets the debug register
   logic [DATA_W-1:0] r_rsp_hold;   // last response value, held between pulses
   logic [DATA_W-1:0] r_mmio;
   logic              w_accept;
   logic              w_is_mmio;
   logic [DATA_W-1:0] w_ram_q;
   logic [DATA_W-1:0] w_rsp_dat;

   // Gating with reset keeps a request presented during reset from touching the RAM
   assign req_ready = (r_state == IDLE) && reset;
   assign w_accept  = req_valid && req_ready;
   assign w_is_mmio = (req_addr == MMIO_A);

   dmem_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .i_clock (clock),
      .i_en    (w_accept),
      .i_we    (req_we),
      .i_addr  (req_addr),
      .i_wdata (req_wdata),
      .o_rdata (w_ram_q)
   );

   // FSM state and wait counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: stores and single-cycle loads go straight to RESP, slower loads count down
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (req_we || (RD_LAT == 1)) begin
                  w_state_nxt = RESP;
               end else begin
                  w_state_nxt = READ_WAIT;
                  w_cnt_nxt   = LD_CNT;
               end
            end
         end
         READ_WAIT: begin
            if (r_cnt <= ONE) begin
               w_state_nxt = RESP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt - ONE;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Load data comes live from the RAM output register during RESP, held afterwards
   always_comb begin
      w_rsp_dat = r_rsp_hold;
      if ((r_state == RESP) && r_rsp_ld) begin
         w_rsp_dat = r_rsp_mmio ? r_mmio : w_ram_q;
      end
   end

   // Access attributes, held response value and the debug register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rsp_ld   <= 1'b0;
         r_rsp_mmio <= 1'b0;
         r_rsp_hold <= '0;
         r_mmio     <= '0;
      end else begin
         if (w_accept) begin
            r_rsp_ld   <= !req_we;
            r_rsp_mmio <= w_is_mmio;
            if (req_we) begin
               r_rsp_hold <= req_wdata;
               if (w_is_mmio) begin
                  r_mmio <= req_wdata;
               end
            end
         end else if (r_state == RESP) begin
            r_rsp_hold <= w_rsp_dat;
         end
      end
   end

   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = w_rsp_dat;
   assign mmio_out  = r_mmio;

endmodule : data_mem_ctrl

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: four instances at RD_LAT 2, 1, 4 and 8.
// Instance 0 carries the functional tests; the others cover the latency sweep.
// All inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_data_mem_ctrl;
   import cpu_pkg::*;

   logic             clock = 1'b0;
   logic             reset;
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [3:0]       req_we;
   logic [3:0][5:0]  req_addr;
   logic [3:0][15:0] req_wdata;
   logic [3:0]       rsp_valid;
   logic [3:0][15:0] rsp_rdata;
   logic [3:0][15:0] mmio_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int pulses [4] = '{0, 0, 0, 0};

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      for (int k = 0; k < 4; k++) begin
         if (rsp_valid[k]) pulses[k]++;
      end
   end

   data_mem_ctrl #(.RD_LAT(2)) u_dut0 (
      .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .mmio_out(mmio_out[0]));

   data_mem_ctrl #(.RD_LAT(1)) u_dut1 (
      .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .mmio_out(mmio_out[1]));

   data_mem_ctrl #(.RD_LAT(4)) u_dut2 (
      .clock(clock), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .mmio_out(mmio_out[2]));

   data_mem_ctrl #(.RD_LAT(8)) u_dut3 (
      .clock(clock), .reset(reset), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
      .req_we(req_we[3]), .req_addr(req_addr[3]), .req_wdata(req_wdata[3]),
      .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]), .mmio_out(mmio_out[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one access on instance k, hold it until accepted, return at the response cycle.
   // lat counts edges from acceptance (inclusive) to the first sample with rsp_valid high.
   task automatic access(input int k, input logic we, input logic [5:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output int lat, output int acc_cyc);
      int w;
      logic busy_bad;
      req_we[k]    = we;
      req_addr[k]  = a;
      req_wdata[k] = d;
      req_valid[k] = 1'b1;
      w = 0;
      while (!req_ready[k] && w < 30) begin
         @(posedge clock); #1;
         w++;
      end
      if (w >= 30) chk("ready_timeout", w, 0);
      @(posedge clock); #1;
      acc_cyc      = cyc;
      req_valid[k] = 1'b0;
      lat      = 1;
      busy_bad = 1'b0;
      while (!rsp_valid[k] && lat < 30) begin
         if (req_ready[k]) busy_bad = 1'b1;
         @(posedge clock); #1;
         lat++;
      end
      if (req_ready[k]) busy_bad = 1'b1;
      rd = rsp_rdata[k];
      chk("ready_low_busy", busy_bad, 0);
   endtask

   function automatic int lat_of(input int k);
      case (k)
         1: return 1;
         2: return 4;
         3: return 8;
         default: return 2;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [15:0] rd;
      int lat, a0, a1, p0, le;

      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      reset     = 1'b1;
      #3 reset  = 1'b0;
      #20;
      chk("rst_rsp_valid", rsp_valid[0], 0);
      chk("rst_rsp_rdata", rsp_rdata[0], 0);
      chk("rst_mmio", mmio_out[0], 0);
      chk("rst_state", 32'(u_dut0.r_state), 32'(IDLE));
      @(posedge clock); #3;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("rst_ready", req_ready[0], 1);

      // 1: store then load of address 5
      access(0, 1'b1, 6'd5, 16'd8, rd, lat, a0);
      chk("t1_st_lat", lat, 1);
      chk("t1_st_dat", rd, 8);
      access(0, 1'b0, 6'd5, 16'd0, rd, lat, a1);
      chk("t1_ld_lat", lat, 2);
      chk("t1_ld_dat", rd, 8);
      chk("t1_st_ld_gap", a1 - a0, 2);
      @(posedge clock); #1;
      chk("t1_pulse_end", rsp_valid[0], 0);
      chk("t1_rdata_hold", rsp_rdata[0], 8);

      // 2: debug register
      access(0, 1'b1, 6'd63, 16'h00A5, rd, lat, a0);
      chk("t2_mmio_set", mmio_out[0], 16'h00A5);
      access(0, 1'b0, 6'd63, 16'd0, rd, lat, a0);
      chk("t2_ld63", rd, 16'h00A5);
      access(0, 1'b1, 6'd62, 16'h1234, rd, lat, a0);
      chk("t2_mmio_keep", mmio_out[0], 16'h00A5);
      access(0, 1'b0, 6'd62, 16'd0, rd, lat, a0);
      chk("t2_ld62", rd, 16'h1234);

      // 3: load held pending behind a store
      @(posedge clock); #1;
      p0 = pulses[0];
      access(0, 1'b1, 6'd7, 16'h0077, rd, lat, a0);
      access(0, 1'b0, 6'd5, 16'd0, rd, lat, a1);
      chk("t3_accept_gap", a1 - a0, 2);
      chk("t3_ld_dat", rd, 8);
      repeat (4) @(posedge clock);
      #1;
      chk("t3_pulses", pulses[0] - p0, 2);

      // 4: latency sweep on the other instances
      for (int k = 1; k < 4; k++) begin
         le = lat_of(k);
         p0 = pulses[k];
         access(k, 1'b1, 6'd10, 16'(16'h0100 + k), rd, lat, a0);
         chk("t4_st_lat", lat, 1);
         access(k, 1'b0, 6'd10, 16'd0, rd, lat, a1);
         chk("t4_ld_lat", lat, le);
         chk("t4_ld_dat", rd, 32'h0100 + k);
         chk("t4_st_gap", a1 - a0, 2);
         access(k, 1'b0, 6'd10, 16'd0, rd, lat, a0);
         chk("t4_ld_gap", a0 - a1, le + 1);
         repeat (3) @(posedge clock);
         #1;
         chk("t4_pulses", pulses[k] - p0, 3);
      end

      // 6: back-to-back stores then loads in reverse order
      access(0, 1'b1, 6'd0, 16'd1, rd, lat, a0);
      for (int i = 1; i < 4; i++) begin
         access(0, 1'b1, 6'(i), 16'(i + 1), rd, lat, a1);
         chk("t6_st_gap", a1 - a0, 2);
         a0 = a1;
      end
      for (int i = 3; i >= 0; i--) begin
         access(0, 1'b0, 6'(i), 16'd0, rd, lat, a1);
         chk("t6_ld_dat", rd, i + 1);
         chk("t6_ld_gap", a1 - a0, (i == 3) ? 2 : 3);
         a0 = a1;
      end

      // 5: reset in READ_WAIT of a load
      @(posedge clock); #1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 6'd5;
      req_valid[0] = 1'b1;
      @(posedge clock); #1;
      req_valid[0] = 1'b0;
      chk("t5_in_wait", 32'(u_dut0.r_state), 32'(READ_WAIT));
      p0 = pulses[0];
      reset = 1'b0;
      #1;
      chk("t5_rsp_valid", rsp_valid[0], 0);
      chk("t5_mmio", mmio_out[0], 0);
      chk("t5_state", 32'(u_dut0.r_state), 32'(IDLE));
      req_we[0]    = 1'b1;
      req_addr[0]  = 6'd5;
      req_wdata[0] = 16'hDEAD;
      req_valid[0] = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      req_valid[0] = 1'b0;
      reset = 1'b1;
      #1;
      chk("t5_no_pulse", pulses[0] - p0, 0);
      chk("t5_ready", req_ready[0], 1);
      access(0, 1'b0, 6'd5, 16'd0, rd, lat, a0);
      chk("t5_ld_dat", rd, 8);
      chk("t5_ld_lat", lat, 2);
      access(0, 1'b0, 6'd63, 16'd0, rd, lat, a0);
      chk("t5_ld63_after_rst", rd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_data_mem_ctrl

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Data-memory controller sitting directly downstream of cpu_core's memory stage; services the core's LD/ST/LDI/STI accesses.
- Owns a 64 x 16-bit single-port RAM and a memory-mapped debug output register.
- Connects to the core through a valid/ready request channel and a single-cycle response pulse.
- Read latency is configurable so the core's memory-stage wait logic can be exercised.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 6: word address width; RAM depth is 2**ADDR_W.
- RD_LAT, 2: edges from request acceptance to the read response; legal range 1..8.
- MMIO_ADDR, 63: address of the debug output register.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  controller can accept an access this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle pulse; the access has completed.
- rsp_rdata  out  DATA_W  load data; for a store, echoes the stored data.
- mmio_out  out  DATA_W  debug register, visible at the top level.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state = IDLE, wait counter = 0
  - rsp_valid = 0, rsp_rdata = 0, mmio_out = 0
  - req_ready = 1 once reset deasserts
  - RAM contents are not reset.
- Handshake:
  - An access is accepted on an edge where req_valid && req_ready.
  - req_ready is 1 only in IDLE.
  - The requester holds req_* stable while req_valid && !req_ready.
  - Requests arriving while not in IDLE are neither lost nor queued; they wait on req_ready.
- FSM states: IDLE, READ_WAIT, RESP.
  - IDLE -> RESP on an accepted store, or on an accepted load when RD_LAT == 1.
  - IDLE -> READ_WAIT on an accepted load when RD_LAT > 1; the counter loads RD_LAT-1.
  - READ_WAIT decrements the counter each cycle and goes -> RESP when it reaches 1.
  - RESP -> IDLE unconditionally after one cycle.
- Store: the RAM write occurs on the acceptance edge. If addr == MMIO_ADDR, mmio_out is updated on the same edge. rsp_valid is high for the single cycle following acceptance, and rsp_rdata = stored data.
- Load: rsp_valid is high for exactly one cycle, starting RD_LAT edges after acceptance, with rsp_rdata = RAM[addr]. If addr == MMIO_ADDR, rsp_rdata = mmio_out instead.
- Throughput:
  - Store: one access per 2 cycles.
  - Load: one access per RD_LAT+1 cycles.
  - A new request can be accepted in the cycle after RESP.
- Load after store to the same address returns the new data; no stale read is permitted.
- rsp_rdata holds its last value when rsp_valid is low.
- Address wrap: ADDR_W-bit addresses cover the full array; there are no out-of-range cases.
- Reset mid-operation (READ_WAIT or RESP):
  - aborts with no rsp_valid pulse;
  - a store already accepted remains written;
  - mmio_out returns to 0.
- Simultaneous req_valid with reset low: ignored.

Decomposition:
- Shared package cpu_pkg: DATA_W and ADDR_W constants (also used by cpu_core), plus enum dmem_state_t {IDLE, READ_WAIT, RESP}.
- One sub-module, dmem_ram: single-port synchronous RAM (write-enable, registered read), 2**ADDR_W x DATA_W, no reset.

Test Plan:
1. Store addr 5 data 8, then load addr 5 (RD_LAT=2):
   - Store: rsp_valid one cycle after acceptance, rsp_rdata = 8.
   - Load: rsp_valid exactly 2 edges after acceptance, rsp_rdata = 8.
   - req_ready low during both busy windows.
2. Store addr 63 data 16'h00A5:
   - mmio_out = 16'h00A5 the cycle after acceptance.
   - Load addr 63 returns 16'h00A5.
   - Store addr 62 leaves mmio_out unchanged.
3. Hold req_valid with a load of addr 5 throughout a preceding store:
   - The load is accepted only when req_ready rises, exactly once.
   - Exactly one rsp_valid pulse is produced per access.
4. RD_LAT sweep {1, 4, 8}: load latency equals RD_LAT edges in each case, and no extra rsp_valid pulses occur.
5. Assert reset low in READ_WAIT of a load:
   - rsp_valid stays 0, mmio_out = 0, state = IDLE.
   - After release, req_ready = 1 and a load of a previously stored address returns its data.
6. Back-to-back: store addr 0..3 with values 1..4, then load addr 3..0 → responses 4, 3, 2, 1 in order, with no gaps beyond the required throughput.
